// File: rtl/nfault_monitor_fsm_pkg.sv
// rtl/nfault_monitor_fsm_pkg.sv - shared types and constants for the nFault monitor
//
// Purpose : state encoding, default timing constants and nFault polarity
//           shared by the monitor top, its interface and the bench.
// Ports   : none (package).
package nfault_monitor_fsm_pkg;

  typedef enum logic [2:0] {
    S_M0,  // idle
    S_M1,  // hold register_address_valid
    S_M2,  // settle, strobe released
    S_M3,  // sample synchronized nFault
    S_M4   // done pulse
  } nfm_state_t;

  localparam int HOLD_CYCLES_DEF       = 4;
  localparam int SETTLE_CYCLES_DEF     = 4;
  localparam int FAULT_COUNT_WIDTH_DEF = 8;

  // Open-drain line pulled high: low means a subsystem is reporting a fault.
  localparam logic NFAULT_ASSERTED = 1'b0;

  // Shared hold/settle down-counter width.
  localparam int CNT_W = 8;

  // Counter preload for an N-cycle state window (exit when the counter hits 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/nfault_monitor_fsm_if.sv
// rtl/nfault_monitor_fsm_if.sv - host/probe bus between the nFault monitor and its master
//
// Purpose : groups command, nFault line and result signals of the monitor.
// Signals : cmd_start, fault_clear, nFault_in      (master -> monitor)
//           register_address_valid, cmd_busy,
//           cmd_done, cmd_fault, sticky_fault,
//           fault_count[FAULT_COUNT_WIDTH]          (monitor -> master)
// Modports: master (host side), slave (monitor side).
interface nfault_monitor_fsm_if #(
  parameter int FAULT_COUNT_WIDTH = 8
);

  logic                         cmd_start;
  logic                         fault_clear;
  logic                         nFault_in;
  logic                         register_address_valid;
  logic                         cmd_busy;
  logic                         cmd_done;
  logic                         cmd_fault;
  logic                         sticky_fault;
  logic [FAULT_COUNT_WIDTH-1:0] fault_count;

  modport master (
    output cmd_start, fault_clear, nFault_in,
    input  register_address_valid, cmd_busy, cmd_done, cmd_fault,
           sticky_fault, fault_count
  );

  modport slave (
    input  cmd_start, fault_clear, nFault_in,
    output register_address_valid, cmd_busy, cmd_done, cmd_fault,
           sticky_fault, fault_count
  );

endinterface

// File: rtl/nfault_monitor_fsm_sync_2ff.sv
// rtl/nfault_monitor_fsm_sync_2ff.sv - two-flop synchronizer for asynchronous inputs
//
// Purpose : brings an asynchronous multi-bit-independent input into the clk domain.
// Ports   : clk     - destination clock
//           reset   - synchronous, active-high; loads RESET_VALUE into both stages
//           d_i     - asynchronous input [WIDTH]
//           q_o     - synchronized output [WIDTH]
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nfault_monitor_fsm.sv
// rtl/nfault_monitor_fsm.sv - bus-master nFault probe sequencer with sticky flag and fault counter
//
// Purpose : on cmd_start strobes register_address_valid for HOLD_CYCLES, waits
//           SETTLE_CYCLES for the addressed subsystem to settle the shared
//           nFault line, samples it and reports the result.
// Ports   : clk    - system clock
//           reset  - synchronous, active-high; aborts any transaction silently
//           nfm_if - slave side of nfault_monitor_fsm_if
//                    (cmd_start, fault_clear, nFault_in in;
//                     register_address_valid, cmd_busy, cmd_done, cmd_fault,
//                     sticky_fault, fault_count out)
// Params  : HOLD_CYCLES 1..255, SETTLE_CYCLES 3..255 (the subsystem FSM needs
//           that long to update nFault), FAULT_COUNT_WIDTH counter width.
module nfault_monitor_fsm
  import nfault_monitor_fsm_pkg::*;
#(
  parameter int HOLD_CYCLES       = HOLD_CYCLES_DEF,
  parameter int SETTLE_CYCLES     = SETTLE_CYCLES_DEF,
  parameter int FAULT_COUNT_WIDTH = FAULT_COUNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  nfault_monitor_fsm_if.slave nfm_if
);

  localparam logic [CNT_W-1:0]             HOLD_LOAD   = cnt_load(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]             SETTLE_LOAD = cnt_load(SETTLE_CYCLES);
  localparam logic [FAULT_COUNT_WIDTH-1:0] COUNT_MAX   = '1;

  nfm_state_t                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic                         cmd_fault_q;
  logic                         sticky_fault_q;
  logic [FAULT_COUNT_WIDTH-1:0] fault_count_q;
  logic [FAULT_COUNT_WIDTH-1:0] count_base;
  logic                         nf_sync;
  logic                         fault_now;

  // Line idles high when a fault is absent; preset to 1 so reset reads "no fault".
  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_nf_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (nfm_if.nFault_in),
    .q_o   (nf_sync)
  );

  assign fault_now = (nf_sync == NFAULT_ASSERTED);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_M0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. cmd_start is only looked at in S_M0, so requests while
  // busy (including the S_M4 cycle) are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_M0: if (nfm_if.cmd_start) state_d = S_M1;
      S_M1: if (cnt_q == '0)      state_d = S_M2;
      S_M2: if (cnt_q == '0)      state_d = S_M3;
      S_M3:                       state_d = S_M4;
      S_M4:                       state_d = S_M0;
      default:                    state_d = S_M0;
    endcase
  end

  // Moore outputs, decoded from the state register only.
  assign nfm_if.register_address_valid = (state_q == S_M1);
  assign nfm_if.cmd_busy               = (state_q != S_M0);
  assign nfm_if.cmd_done               = (state_q == S_M4);

  // A clear zeroes the counter base, so a coincident faulted sample lands on 1.
  assign count_base = nfm_if.fault_clear ? '0 : fault_count_q;

  // Window counter and fault bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      cmd_fault_q    <= 1'b0;
      sticky_fault_q <= 1'b0;
      fault_count_q  <= '0;
    end else begin
      case (state_q)
        S_M0: if (nfm_if.cmd_start) cnt_q <= HOLD_LOAD;
        S_M1: cnt_q <= (cnt_q == '0) ? SETTLE_LOAD : cnt_q - 1'b1;
        S_M2: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      // Result is latched at the sample so it is already valid during cmd_done
      // and holds until the next transaction samples again.
      if (state_q == S_M3) begin
        cmd_fault_q <= fault_now;
      end

      if (state_q == S_M3 && fault_now) begin
        sticky_fault_q <= 1'b1;
        fault_count_q  <= (count_base == COUNT_MAX) ? count_base : count_base + 1'b1;
      end else if (nfm_if.fault_clear) begin
        sticky_fault_q <= 1'b0;
        fault_count_q  <= '0;
      end
    end
  end

  assign nfm_if.cmd_fault    = cmd_fault_q;
  assign nfm_if.sticky_fault = sticky_fault_q;
  assign nfm_if.fault_count  = fault_count_q;

endmodule

// File: tb/tb_nfault_monitor_fsm.sv
// tb/tb_nfault_monitor_fsm.sv - directed self-checking bench for nfault_monitor_fsm
module tb_nfault_monitor_fsm;
  import nfault_monitor_fsm_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  nfault_monitor_fsm_if #(.FAULT_COUNT_WIDTH(8)) nfm_if ();
  nfault_monitor_fsm_if #(.FAULT_COUNT_WIDTH(2)) nfm_if_w2 ();

  nfault_monitor_fsm #(
    .HOLD_CYCLES       (4),
    .SETTLE_CYCLES     (4),
    .FAULT_COUNT_WIDTH (8)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .nfm_if (nfm_if.slave)
  );

  // Narrow-counter instance sees identical stimulus for the saturation check.
  nfault_monitor_fsm #(
    .HOLD_CYCLES       (4),
    .SETTLE_CYCLES     (4),
    .FAULT_COUNT_WIDTH (2)
  ) u_dut_w2 (
    .clk    (clk),
    .reset  (reset),
    .nfm_if (nfm_if_w2.slave)
  );

  assign nfm_if_w2.cmd_start   = nfm_if.cmd_start;
  assign nfm_if_w2.fault_clear = nfm_if.fault_clear;
  assign nfm_if_w2.nFault_in   = nfm_if.nFault_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " rav"},   32'(nfm_if.register_address_valid), 0);
    check_eq({tag, " busy"},  32'(nfm_if.cmd_busy), 0);
    check_eq({tag, " done"},  32'(nfm_if.cmd_done), 0);
    check_eq({tag, " fault"}, 32'(nfm_if.cmd_fault), 0);
    check_eq({tag, " sticky"},32'(nfm_if.sticky_fault), 0);
    check_eq({tag, " count"}, 32'(nfm_if.fault_count), 0);
    check_eq({tag, " count_w2"}, 32'(nfm_if_w2.fault_count), 0);
  endtask

  // One probe: cmd_start sampled at the edge ending cycle 0, observation in
  // cycles 1..11. Extra cmd_start pulses in cycles ign_a/ign_b, fault_clear in
  // cycle clr_at, nFault_in low from cycle fault_from (0 = never).
  task automatic run_probe(input int fault_from, input int ign_a, input int ign_b,
                           input int clr_at, input logic exp_fault);
    nfm_if.cmd_start = 1'b1;
    step();
    nfm_if.cmd_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_eq($sformatf("rav c%0d", c),  32'(nfm_if.register_address_valid), 32'(c <= 4));
      check_eq($sformatf("busy c%0d", c), 32'(nfm_if.cmd_busy), 1);
      check_eq($sformatf("done c%0d", c), 32'(nfm_if.cmd_done), 32'(c == 10));
      if (c == 10) check_eq("cmd_fault", 32'(nfm_if.cmd_fault), 32'(exp_fault));
      nfm_if.nFault_in   = (fault_from != 0 && c >= fault_from) ? 1'b0 : 1'b1;
      nfm_if.cmd_start   = (c == ign_a || c == ign_b);
      nfm_if.fault_clear = (c == clr_at);
      step();
    end
    nfm_if.cmd_start   = 1'b0;
    nfm_if.fault_clear = 1'b0;
    nfm_if.nFault_in   = 1'b1;
    check_eq("busy c11", 32'(nfm_if.cmd_busy), 0);
    check_eq("done c11", 32'(nfm_if.cmd_done), 0);
    check_eq("cmd_fault hold c11", 32'(nfm_if.cmd_fault), 32'(exp_fault));
  endtask

  task automatic pulse_clear();
    nfm_if.fault_clear = 1'b1;
    step();
    nfm_if.fault_clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset              = 1'b1;
    nfm_if.cmd_start   = 1'b0;
    nfm_if.fault_clear = 1'b0;
    nfm_if.nFault_in   = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // 1: clean probe
    run_probe(0, 0, 0, 0, 1'b0);
    check_eq("s1 sticky", 32'(nfm_if.sticky_fault), 0);
    check_eq("s1 count",  32'(nfm_if.fault_count), 0);

    // 2: faulted probes
    run_probe(6, 0, 0, 0, 1'b1);
    check_eq("s2 sticky", 32'(nfm_if.sticky_fault), 1);
    check_eq("s2 count",  32'(nfm_if.fault_count), 1);
    run_probe(6, 0, 0, 0, 1'b1);
    check_eq("s2 count2", 32'(nfm_if.fault_count), 2);

    // 3: saturation of the 2-bit counter, then clear
    pulse_clear();
    check_eq("s3 clr sticky",   32'(nfm_if.sticky_fault), 0);
    check_eq("s3 clr count",    32'(nfm_if.fault_count), 0);
    check_eq("s3 clr count_w2", 32'(nfm_if_w2.fault_count), 0);
    for (int i = 1; i <= 5; i++) begin
      run_probe(6, 0, 0, 0, 1'b1);
      check_eq($sformatf("s3 count p%0d", i),    32'(nfm_if.fault_count), 32'(i));
      check_eq($sformatf("s3 count_w2 p%0d", i), 32'(nfm_if_w2.fault_count), 32'((i > 3) ? 3 : i));
      check_eq($sformatf("s3 sticky_w2 p%0d", i), 32'(nfm_if_w2.sticky_fault), 1);
    end
    pulse_clear();
    check_eq("s3 end sticky",    32'(nfm_if.sticky_fault), 0);
    check_eq("s3 end count",     32'(nfm_if.fault_count), 0);
    check_eq("s3 end sticky_w2", 32'(nfm_if_w2.sticky_fault), 0);
    check_eq("s3 end count_w2",  32'(nfm_if_w2.fault_count), 0);

    // 4: starts while busy are dropped; start right after done is taken
    run_probe(0, 3, 9, 0, 1'b0);
    run_probe(0, 0, 0, 0, 1'b0);
    run_probe(0, 10, 0, 0, 1'b0);
    step();
    check_eq("s4 no queued start", 32'(nfm_if.cmd_busy), 0);

    // 5: clear coincident with a faulted sample
    run_probe(6, 0, 0, 0, 1'b1);
    check_eq("s5 pre count", 32'(nfm_if.fault_count), 1);
    run_probe(6, 0, 0, 9, 1'b1);
    check_eq("s5 sticky", 32'(nfm_if.sticky_fault), 1);
    check_eq("s5 count",  32'(nfm_if.fault_count), 1);

    // 6: reset during settle aborts silently
    nfm_if.cmd_start = 1'b1;
    step();
    nfm_if.cmd_start = 1'b0;
    repeat (5) step();
    check_eq("s6 in settle", 32'(nfm_if.cmd_busy), 1);
    reset = 1'b1;
    step();
    check_idle_outputs("s6 reset");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("s6 no done %0d", c), 32'(nfm_if.cmd_done), 0);
      check_eq($sformatf("s6 idle %0d", c),    32'(nfm_if.cmd_busy), 0);
      step();
    end
    run_probe(0, 0, 0, 0, 1'b0);
    check_eq("s6 sticky", 32'(nfm_if.sticky_fault), 0);
    check_eq("s6 count",  32'(nfm_if.fault_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
